// File: rtl/mem_port_arbiter_if.sv
// Bundle shared by the fetch requester, the memory-stage requester and the
// single RAM port that mem_port_arbiter multiplexes between them.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_read_data,
        output if_ack, if_rvalid, if_rdata, dm_ack, dm_rvalid, dm_rdata,
               mem_addr, mem_read_en, mem_write_en, mem_write_data
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_read_data,
        input  if_ack, if_rvalid, if_rdata, dm_ack, dm_rvalid, dm_rdata,
               mem_addr, mem_read_en, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch (read-only) and the memory
// stage (load/store); memory stage has priority with a fetch starvation cap.
module mem_port_arbiter #(
    parameter int DATA_ADDR_WIDTH = 8,
    parameter int WORD_SIZE       = 32,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    localparam int STAGES = 2;
    localparam int SW     = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic                       re;
        logic                       we;
        logic [DATA_ADDR_WIDTH-1:0] addr;
        logic [WORD_SIZE-1:0]       wdata;
    } cmd_t;

    typedef struct packed {
        logic                 if_rvalid;
        logic                 dm_rvalid;
        logic [WORD_SIZE-1:0] rdata;
    } rsp_t;

    logic          if_gnt, dm_gnt, rd_gnt, starved;
    logic [SW-1:0] streak_q, streak_d;
    cmd_t          cmd_q;
    rsp_t          rsp_q;

    // Tag pipeline: bit 1 follows the command stage, bit STAGES the response.
    logic [STAGES:1] vld_pipe_q;
    logic [STAGES:1] src_pipe_q;

    always_comb begin
        starved  = (streak_q == SW'(STARVE_LIMIT));
        dm_gnt   = rst_n & bus.dm_req & ~(bus.if_req & starved);
        if_gnt   = rst_n & bus.if_req & ~dm_gnt;
        rd_gnt   = if_gnt | (dm_gnt & ~bus.dm_we);
        streak_d = streak_q;
        if (!bus.if_req || if_gnt) begin
            streak_d = '0;
        end else if (dm_gnt && !starved) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q   <= '0;
            cmd_q      <= '0;
            rsp_q      <= '0;
            vld_pipe_q <= '0;
            src_pipe_q <= '0;
        end else begin
            streak_q <= streak_d;
            cmd_q.re <= rd_gnt;
            cmd_q.we <= dm_gnt & bus.dm_we;
            if (if_gnt) begin
                cmd_q.addr <= bus.if_addr;
            end else if (dm_gnt) begin
                cmd_q.addr <= bus.dm_addr;
            end
            if (dm_gnt && bus.dm_we) begin
                cmd_q.wdata <= bus.dm_wdata;
            end
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], rd_gnt};
            src_pipe_q <= {src_pipe_q[STAGES-1:1], dm_gnt};
            // The RAM presents read data during the command cycle (it samples
            // on the falling edge), so it is captured at the end of that cycle.
            rsp_q.if_rvalid <= vld_pipe_q[STAGES-1] & ~src_pipe_q[STAGES-1];
            rsp_q.dm_rvalid <= vld_pipe_q[STAGES-1] &  src_pipe_q[STAGES-1];
            if (vld_pipe_q[STAGES-1]) begin
                rsp_q.rdata <= bus.mem_read_data;
            end
        end
    end

    assign bus.if_ack         = if_gnt;
    assign bus.dm_ack         = dm_gnt;
    assign bus.mem_addr       = cmd_q.addr;
    assign bus.mem_read_en    = cmd_q.re;
    assign bus.mem_write_en   = cmd_q.we;
    assign bus.mem_write_data = cmd_q.wdata;
    assign bus.if_rvalid      = rsp_q.if_rvalid;
    assign bus.dm_rvalid      = rsp_q.dm_rvalid;
    assign bus.if_rdata       = rsp_q.rdata;
    assign bus.dm_rdata       = rsp_q.rdata;

    a_one_ack: assert property (@(posedge clk) !(bus.if_ack && bus.dm_ack));
    a_ack_req: assert property (@(posedge clk)
        (!bus.if_ack || bus.if_req) && (!bus.dm_ack || bus.dm_req));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queue-based response model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LIM = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.DATA_ADDR_WIDTH(AW), .WORD_SIZE(DW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // phy_mem stand-in, clocked on the inverted clock
    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];
    always @(negedge clk) begin
        if (bus.mem_write_en) ram[bus.mem_addr] <= bus.mem_write_data;
        if (bus.mem_read_en)  bus.mem_read_data <= ram[bus.mem_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: pending reads are a queue of (cycle due, requester, word).
    typedef struct {
        int            due;
        bit            src_dm;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t rq[$];

    int            cyc = 0;
    int            fetch_wait = 0;
    logic          e_re = 0, e_we = 0, e_irv = 0, e_drv = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0, e_rd = '0;

    initial forever begin
        logic e_if, e_dm;
        rsp_t r;
        @(posedge clk);
        #3;
        cyc++;
        e_dm = rst_n && bus.dm_req && !(bus.if_req && fetch_wait == LIM);
        e_if = rst_n && bus.if_req && !e_dm;
        chk("if_ack",         32'(bus.if_ack),         32'(e_if));
        chk("dm_ack",         32'(bus.dm_ack),         32'(e_dm));
        chk("mem_read_en",    32'(bus.mem_read_en),    32'(e_re));
        chk("mem_write_en",   32'(bus.mem_write_en),   32'(e_we));
        chk("mem_addr",       32'(bus.mem_addr),       32'(e_addr));
        chk("mem_write_data", bus.mem_write_data,      e_wd);
        chk("if_rvalid",      32'(bus.if_rvalid),      32'(e_irv));
        chk("dm_rvalid",      32'(bus.dm_rvalid),      32'(e_drv));
        chk("if_rdata",       bus.if_rdata,            e_rd);
        chk("dm_rdata",       bus.dm_rdata,            e_rd);
        if (!rst_n) begin
            rq.delete();
            fetch_wait = 0;
            {e_re, e_we, e_irv, e_drv} = '0;
            e_addr = '0; e_wd = '0; e_rd = '0;
        end else begin
            e_irv = 0; e_drv = 0;
            if (rq.size() > 0 && rq[0].due == cyc + 1) begin
                r = rq.pop_front();
                if (r.src_dm) e_drv = 1; else e_irv = 1;
                e_rd = r.data;
            end
            e_re = 0; e_we = 0;
            if (e_if) begin
                e_re = 1; e_addr = bus.if_addr;
                rq.push_back('{cyc + 2, 1'b0, shadow[bus.if_addr]});
            end else if (e_dm) begin
                e_addr = bus.dm_addr;
                if (bus.dm_we) begin
                    e_we = 1; e_wd = bus.dm_wdata;
                    shadow[bus.dm_addr] = bus.dm_wdata;
                end else begin
                    e_re = 1;
                    rq.push_back('{cyc + 2, 1'b1, shadow[bus.dm_addr]});
                end
            end
            if (!bus.if_req || e_if) fetch_wait = 0;
            else if (e_dm)           fetch_wait++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        bus.if_req = 0; bus.dm_req = 0; bus.dm_we = 0;
        repeat (n) nxt();
    endtask

    initial begin
        logic [11:0] pat12;
        logic [8:0]  rvi, rvd;
        logic [3:0]  pat4;
        logic [AW-1:0] ia, da;
        int acks;

        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'hA500_0000 | i;
            shadow[i] = 32'hA500_0000 | i;
        end
        ram[16] = 32'hDEAD_BEEF; shadow[16] = 32'hDEAD_BEEF;
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;

        // Reset held for two cycles
        nxt(); nxt();
        chk("rst_outputs", 32'({bus.if_ack, bus.dm_ack, bus.if_rvalid, bus.dm_rvalid,
            bus.mem_read_en, bus.mem_write_en}), 32'h0);
        chk("rst_addr_data", 32'(bus.mem_addr) | bus.mem_write_data | bus.if_rdata, 32'h0);

        // Isolated fetch at 0x10
        rst_n = 1; bus.if_req = 1; bus.if_addr = 8'h10;
        #1 chk("fetch_ack", 32'(bus.if_ack), 32'h1);
        nxt(); bus.if_req = 0;
        chk("fetch_cmd", 32'({bus.mem_read_en, bus.mem_write_en, bus.mem_addr}), 32'h210);
        nxt();
        chk("fetch_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'h2);
        chk("fetch_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        idle(2);

        // Store 0x12345678 to 0x20, then load it back
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 8'h20; bus.dm_wdata = 32'h1234_5678;
        #1 chk("store_ack", 32'(bus.dm_ack), 32'h1);
        nxt(); bus.dm_we = 0;
        chk("store_cmd", 32'({bus.mem_read_en, bus.mem_write_en, bus.mem_addr}), 32'h120);
        chk("store_wdata", bus.mem_write_data, 32'h1234_5678);
        #1 chk("load_ack", 32'(bus.dm_ack), 32'h1);
        nxt(); bus.dm_req = 0;
        chk("store_no_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'h0);
        nxt();
        chk("raw_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'h1);
        chk("raw_rdata", bus.dm_rdata, 32'h1234_5678);
        idle(2);

        // Contention: both asking continuously
        ia = 8'h30; da = 8'h40; pat12 = '0;
        bus.if_req = 1; bus.dm_req = 1; bus.dm_we = 0;
        for (int k = 0; k < 12; k++) begin
            bus.if_addr = ia; bus.dm_addr = da;
            #1;
            pat12 = {pat12[10:0], bus.if_ack};
            if (bus.if_ack) ia++;
            if (bus.dm_ack) da++;
            nxt();
        end
        chk("starve_pattern", 32'(pat12), 32'h111);
        idle(3);

        // Interleaved fetch 0x0 / load 0x1, then three idle cycles
        rvi = '0; rvd = '0;
        for (int k = 0; k < 9; k++) begin
            bus.if_req = (k < 6) && (k % 2 == 0); bus.if_addr = 8'h00;
            bus.dm_req = (k < 6) && (k % 2 == 1); bus.dm_addr = 8'h01; bus.dm_we = 0;
            #1;
            rvi = {rvi[7:0], bus.if_rvalid};
            rvd = {rvd[7:0], bus.dm_rvalid};
            if (k >= 7) begin
                chk("idle_enables", 32'({bus.mem_read_en, bus.mem_write_en}), 32'h0);
                chk("idle_addr_hold", 32'(bus.mem_addr), 32'h1);
            end
            nxt();
        end
        chk("interleave_if_rv", 32'(rvi), 32'h054);
        chk("interleave_dm_rv", 32'(rvd), 32'h02A);

        // Fetch-only stream
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            bus.if_req = 1; bus.if_addr = 8'h10 + 8'(k); bus.dm_req = 0;
            #1 acks += int'(bus.if_ack);
            nxt();
        end
        chk("fetch_stream_acks", 32'(acks), 32'd4);
        idle(3);

        // Reset with two reads in flight
        bus.if_req = 1; bus.if_addr = 8'h10;
        #1 chk("pre_rst_fetch_ack", 32'(bus.if_ack), 32'h1);
        nxt(); bus.if_addr = 8'h12; bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 8'h11;
        #1 chk("pre_rst_load_ack", 32'({bus.if_ack, bus.dm_ack}), 32'h1);
        nxt(); bus.dm_addr = 8'h13; rst_n = 0;
        #1 chk("rst_acks_low", 32'({bus.if_ack, bus.dm_ack}), 32'h0);
        nxt();
        chk("rst_flush", 32'({bus.if_rvalid, bus.dm_rvalid, bus.mem_read_en}), 32'h0);
        nxt(); rst_n = 1;
        ia = 8'h12; da = 8'h13; pat4 = '0;
        for (int k = 0; k < 4; k++) begin
            bus.if_addr = ia; bus.dm_addr = da;
            #1;
            if (k < 2) chk("post_rst_no_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'h0);
            pat4 = {pat4[2:0], bus.if_ack};
            if (bus.if_ack) ia++;
            if (bus.dm_ack) da++;
            nxt();
        end
        chk("post_rst_pattern", 32'(pat4), 32'h1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer in front of the single-port data/instruction RAM `phy_mem`. It shares that one port between the instruction-fetch stage, which only reads, and the memory stage, which loads and stores. The memory stage has priority, with a bounded-starvation guard for fetch. It also tracks in-flight reads so each returned word reaches the requester that issued it.

## Interface
Parameters (width macros from `common.h.v`):
- `data_addr_width`, global macro: RAM word-address width.
- `word_size`, global macro: data word width.
- `STARVE_LIMIT`, default 3: maximum consecutive memory-stage grants while fetch waits.

Ports:
- `clk`  in  1  system clock; `phy_mem` is fed the inverted clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  `data_addr_width`  fetch address.
- `if_ack`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  `if_rdata` valid this cycle.
- `if_rdata`  out  `word_size`  fetched word.
- `dm_req`  in  1  memory-stage request.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  `data_addr_width`  memory-stage address.
- `dm_wdata`  in  `word_size`  store data.
- `dm_ack`  out  1  memory-stage request accepted this cycle.
- `dm_rvalid`  out  1  `dm_rdata` valid this cycle.
- `dm_rdata`  out  `word_size`  loaded word.
- `mem_addr`  out  `data_addr_width`  to `phy_mem.addr`.
- `mem_read_en`  out  1  to `phy_mem.read_en`.
- `mem_write_en`  out  1  to `phy_mem.write_en`.
- `mem_write_data`  out  `word_size`  to `phy_mem.write_data`.
- `mem_read_data`  in  `word_size`  from `phy_mem.read_data`.

## Operation
- **Arbitration.** Combinational, evaluated every cycle. Exactly one of `if_ack`/`dm_ack` may be high. An ack is asserted only for a requester whose req is high.
- **Default winner.** `dm` wins if `dm_req`. `if` wins if only `if_req`.
- **Starvation guard.** `streak` is a counter from 0 to `STARVE_LIMIT`.
  - Increments on a `dm` grant while `if_req` = 1.
  - Clears on an `if` grant, or in any cycle with `if_req` = 0.
  - When `streak == STARVE_LIMIT` and both requesters are asking, `if` wins.
  - Result: fetch waits at most `STARVE_LIMIT` cycles.
- **Command stage.** The granted command is registered on the next edge and drives the `mem_*` outputs for exactly one cycle.
  - Store: `mem_write_en` = 1, `mem_read_en` = 0.
  - Load or fetch: `mem_read_en` = 1, `mem_write_en` = 0.
- **No grant.** Both enables are 0. `mem_addr` and `mem_write_data` hold their last values.
- **Return pipeline.** A 2-stage tag pipeline (valid + source bit) follows each read. Stores carry no tag.
- **Response.** In the response cycle, `mem_read_data` is registered into both `if_rdata` and `dm_rdata`. Only the tagged requester's rvalid pulses. The rdata registers hold between responses.
- **Requester rule.** A requester keeps req, addr, we and wdata stable until it sees its ack. It may present a new request in the cycle after the ack.
- **Reads per cycle.** At most one read is returned per cycle, and responses arrive in issue order.
- **Reset.** When `rst_n` = 0 at an edge:
  - Every output goes to 0, `streak` to 0, and the tag pipeline is flushed.
  - Reads in flight at reset produce no rvalid.
  - Acks are forced to 0 while `rst_n` = 0.

## Timing
- Cycle N: request and ack are both high (ack is combinational).
- Cycle N+1: `mem_*` command is driven. `phy_mem` samples it on the falling edge.
- Cycle N+2: `*_rvalid` = 1 and `*_rdata` = word. Load-use latency from ack is 2 cycles.
- Throughput: one access per cycle, with fetch and data interleaved freely.
- Read-after-write, same address: store acked at N, load acked at N+1. The load's rvalid at N+3 returns the stored data.
- Simultaneous requests in one cycle: a single grant follows the priority rules. The loser's ack stays 0 and it holds its request.

## Test plan
- Reset, then an isolated fetch:
  - Hold `rst_n` = 0 for 2 cycles → all outputs are 0.
  - Release, then fetch at address 0x10 (memory initialized so word = 0xDEADBEEF) → `if_ack` at N, `mem_read_en` at N+1, `if_rvalid` with 0xDEADBEEF at N+2, `dm_rvalid` stays 0.
- Store then load:
  - Store 0x12345678 to 0x20 at N → `mem_write_en` at N+1, no rvalid.
  - Load 0x20 at N+1 → `dm_rvalid` with 0x12345678 at N+3.
- Contention and starvation:
  - `if_req` and `dm_req` both held high, `STARVE_LIMIT` = 3 → ack pattern is dm, dm, dm, if, repeating.
  - Every `if` response returns the data for its own address.
- Interleaved returns:
  - Alternate fetch at 0x0 and load at 0x1 on consecutive cycles → rvalids alternate `if`/`dm` two cycles after each ack.
  - No response is misrouted or duplicated.
- Idle gaps:
  - Drop all requests for 3 cycles → both enables are 0 and `mem_addr` holds.
  - Fetch only, with `dm_req` = 0 → `if_ack` on every cycle that `if_req` is high.
- Reset mid-operation:
  - Two reads outstanding when `rst_n` = 0 at N+1 → no rvalid in any later cycle and `streak` = 0.
  - The first request after reset is serviced normally.
